fpu_cmp_scheduler: RTL

- Shares one multi-cycle FP32 compare datapath between NREQ requesters, e.g. the FPU execute slot and the branch/CSR path.
- Arbitration is round-robin.
- Operands pass through two registered compare stages: sign/exponent/NaN classification, then fraction magnitude.
- The result returns over a valid/ready response channel tagged with requester ID and destination tag.
- Implements RISC-V FEQ.S / FLT.S / FLE.S semantics, including the NV exception flag.

---
 rtl/fpu_cmp_pkg.sv | 37 +++
 rtl/fp_frac_compare.sv | 14 +
 rtl/fpu_cmp_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_cmp_pkg.sv
// rtl/fpu_cmp_pkg.sv - types and constants shared by the FP32 compare scheduler
package fpu_cmp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;
    localparam int QNAN_BIT  = 22;

    typedef enum logic [1:0] {
        CMP_FEQ  = 2'b00,
        CMP_FLT  = 2'b01,
        CMP_FLE  = 2'b10,
        CMP_RSVD = 2'b11
    } cmp_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        FRAC = 2'd2,
        RESP = 2'd3
    } cmp_state_t;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    function automatic logic fp_is_nan(input fp32_t x);
        return (x.exp == FP_EXP_MAX) && (x.frac != '0);
    endfunction

    function automatic logic fp_is_zero(input fp32_t x);
        return (x.exp == '0) && (x.frac == '0);
    endfunction

endpackage

// File: rtl/fp_frac_compare.sv
// rtl/fp_frac_compare.sv - combinational unsigned compare of two FP32 fraction fields
module fp_frac_compare
    import fpu_cmp_pkg::*;
(
    input  logic [FP_FRAC_W-1:0] frac_a,
    input  logic [FP_FRAC_W-1:0] frac_b,
    output logic                 frac_lt,
    output logic                 frac_eq
);

    assign frac_lt = (frac_a < frac_b);
    assign frac_eq = (frac_a == frac_b);

endmodule

// File: rtl/fpu_cmp_scheduler.sv
// rtl/fpu_cmp_scheduler.sv - round-robin shared FP32 compare unit (FEQ/FLT/FLE)
module fpu_cmp_scheduler
    import fpu_cmp_pkg::*;
#(
    parameter  int NREQ  = 2,
    parameter  int TAG_W = 5,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [32*NREQ-1:0]    req_a,
    input  logic [32*NREQ-1:0]    req_b,
    input  logic [TAG_W*NREQ-1:0] req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  rsp_result,
    output logic                  rsp_nv
);

    cmp_state_t       state_q;
    logic [ID_W-1:0]  last_grant_q;
    fp32_t            a_q, b_q;
    cmp_op_t          op_q;
    logic [TAG_W-1:0] tag_q;
    logic [ID_W-1:0]  id_q;

    logic sign_a_q, sign_b_q, exp_eq_q, exp_lt_q, zero_a_q, zero_b_q;
    logic nan_a_q, nan_b_q, snan_a_q, snan_b_q;

    logic             rsp_valid_q, rsp_result_q, rsp_nv_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [TAG_W-1:0] rsp_tag_q;

    logic [ID_W-1:0] grant, idx;
    logic            grant_found, accept;
    logic            frac_lt, frac_eq;
    logic            mag_lt, mag_eq, ord_lt, ord_eq, any_nan;
    logic            res_d, nv_d;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = ID_W'((int'(last_grant_q) + i) % NREQ);
            if (!grant_found && req_valid[idx]) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
    end

    assign accept = (state_q == IDLE) && !flush && !RST && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    fp_frac_compare u_frac_cmp (
        .frac_a  (a_q.frac),
        .frac_b  (b_q.frac),
        .frac_lt (frac_lt),
        .frac_eq (frac_eq)
    );

    // Ordering on {exp,frac}; sign then flips or overrides it, and +0 == -0.
    always_comb begin
        mag_lt  = exp_lt_q || (exp_eq_q && frac_lt);
        mag_eq  = exp_eq_q && frac_eq;
        ord_lt  = 1'b0;
        ord_eq  = 1'b0;
        any_nan = nan_a_q || nan_b_q;
        if (zero_a_q && zero_b_q) begin
            ord_eq = 1'b1;
        end else if (sign_a_q != sign_b_q) begin
            ord_lt = sign_a_q;
        end else if (sign_a_q) begin
            ord_lt = !mag_lt && !mag_eq;
            ord_eq = mag_eq;
        end else begin
            ord_lt = mag_lt;
            ord_eq = mag_eq;
        end
        res_d = 1'b0;
        nv_d  = 1'b0;
        case (op_q)
            CMP_FEQ: begin
                res_d = !any_nan && ord_eq;
                nv_d  = snan_a_q || snan_b_q;
            end
            CMP_FLT: begin
                res_d = !any_nan && ord_lt;
                nv_d  = any_nan;
            end
            CMP_FLE: begin
                res_d = !any_nan && (ord_lt || ord_eq);
                nv_d  = any_nan;
            end
            default: begin
                res_d = 1'b0;
                nv_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NREQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= CMP_FEQ;
            tag_q        <= '0;
            id_q         <= '0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            exp_eq_q     <= 1'b0;
            exp_lt_q     <= 1'b0;
            zero_a_q     <= 1'b0;
            zero_b_q     <= 1'b0;
            nan_a_q      <= 1'b0;
            nan_b_q      <= 1'b0;
            snan_a_q     <= 1'b0;
            snan_b_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_tag_q    <= '0;
            rsp_result_q <= 1'b0;
            rsp_nv_q     <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= req_a[int'(grant)*32 +: 32];
                        b_q          <= req_b[int'(grant)*32 +: 32];
                        op_q         <= cmp_op_t'(req_op[int'(grant)*2 +: 2]);
                        tag_q        <= req_tag[int'(grant)*TAG_W +: TAG_W];
                        id_q         <= grant;
                        last_grant_q <= grant;
                        state_q      <= EXP;
                    end
                end
                EXP: begin
                    sign_a_q <= a_q.sign;
                    sign_b_q <= b_q.sign;
                    exp_eq_q <= (a_q.exp == b_q.exp);
                    exp_lt_q <= (a_q.exp < b_q.exp);
                    zero_a_q <= fp_is_zero(a_q);
                    zero_b_q <= fp_is_zero(b_q);
                    nan_a_q  <= fp_is_nan(a_q);
                    nan_b_q  <= fp_is_nan(b_q);
                    snan_a_q <= fp_is_nan(a_q) && !a_q.frac[QNAN_BIT];
                    snan_b_q <= fp_is_nan(b_q) && !b_q.frac[QNAN_BIT];
                    state_q  <= FRAC;
                end
                FRAC: begin
                    rsp_result_q <= res_d;
                    rsp_nv_q     <= nv_d;
                    rsp_id_q     <= id_q;
                    rsp_tag_q    <= tag_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_result = rsp_result_q;
    assign rsp_nv     = rsp_nv_q;

endmodule
